// File: rtl/reg_scoreboard_if.sv
// Bundle between the decode/hdu side and the pending-write scoreboard.
// The master drives decode, issue and writeback information. The slave
// (the scoreboard) returns the hazard flags, the busy vector and the error pulse.
interface reg_scoreboard_if #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DELAY_W    = 7
);
  logic                  ins_v;
  logic [REG_ADDR_W-1:0] rD_addr;
  logic [REG_ADDR_W-1:0] rA_addr;
  logic [REG_ADDR_W-1:0] rB_addr;
  logic                  rD_used;
  logic                  rA_used;
  logic                  rB_used;
  logic                  issue_ok;
  logic [DELAY_W-1:0]    issue_delay;
  logic                  issue_var;
  logic                  wb_v;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic                  rD_conflict;
  logic                  rS_conflict;
  logic [NUM_REGS-1:0]   pending;
  logic                  wb_err;

  modport master (
    output ins_v, rD_addr, rA_addr, rB_addr, rD_used, rA_used, rB_used,
           issue_ok, issue_delay, issue_var, wb_v, wb_addr,
    input  rD_conflict, rS_conflict, pending, wb_err
  );

  modport slave (
    input  ins_v, rD_addr, rA_addr, rB_addr, rD_used, rA_used, rB_used,
           issue_ok, issue_delay, issue_var, wb_v, wb_addr,
    output rD_conflict, rS_conflict, pending, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard feeding the hdu stall logic.
// Each register has a busy bit, a variable-latency flag and a countdown.
// Fixed-latency entries expire through the countdown. Variable-latency
// entries (div/mod/sqrt) expire on a matching writeback strobe.
// Optional macro SB_BYPASS_EN: source hazards are suppressed in the cycle
// where the result is forwarded (last countdown cycle, or a same-cycle
// variable writeback). Destination hazards always use the plain busy bit.
module reg_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DELAY_W    = 7
) (
  input logic            clk,
  input logic            reset,
  reg_scoreboard_if.slave sb
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] is_var;
  logic [DELAY_W-1:0]  cnt [NUM_REGS];
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] hz;
  logic                issue_set;
  logic                wb_bad;
  logic                wb_err_q;

  // Decode which entry is loaded by this issue, which entry is retired by the
  // writeback strobe, and whether the strobe points at a valid var entry
  always_comb begin
    issue_set = sb.issue_ok && sb.rD_used && (sb.rD_addr != '0) &&
                (sb.issue_var || (sb.issue_delay != '0));
    set_vec = '0;
    wb_hit  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      set_vec[r] = issue_set && (sb.rD_addr == REG_ADDR_W'(r));
      wb_hit[r]  = sb.wb_v && (sb.wb_addr == REG_ADDR_W'(r)) && pend[r] && is_var[r];
    end
    wb_bad = sb.wb_v && (sb.wb_addr != '0) &&
             !(pend[sb.wb_addr] && is_var[sb.wb_addr]);
  end

  // Entry update: a set overrides any countdown or writeback on the same register
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      is_var   <= '0;
      wb_err_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      wb_err_q <= wb_bad;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (set_vec[r]) begin
          pend[r]   <= 1'b1;
          is_var[r] <= sb.issue_var;
          cnt[r]    <= sb.issue_delay;
        end else if (pend[r] && !is_var[r]) begin
          cnt[r] <= cnt[r] - DELAY_W'(1);
          if (cnt[r] == DELAY_W'(1)) begin
            pend[r] <= 1'b0;
          end
        end else if (wb_hit[r]) begin
          pend[r]   <= 1'b0;
          is_var[r] <= 1'b0;
        end
      end
    end
  end

  // Source-hazard view of each register; reg 0 never reports a hazard
  always_comb begin
    hz = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      hz[r] = pend[r];
`ifdef SB_BYPASS_EN
      if (!is_var[r] && (cnt[r] == DELAY_W'(1))) begin
        hz[r] = 1'b0;
      end
      if (wb_hit[r]) begin
        hz[r] = 1'b0;
      end
`endif
    end
    hz[0] = 1'b0;
  end

  assign sb.rS_conflict = sb.ins_v && ((sb.rA_used && hz[sb.rA_addr]) ||
                                       (sb.rB_used && hz[sb.rB_addr]));
  assign sb.rD_conflict = sb.ins_v && sb.rD_used && pend[sb.rD_addr] &&
                          (sb.rD_addr != '0);
  assign sb.pending     = pend;
  assign sb.wb_err      = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard. The stimulus side drives one cycle
// at a time and pushes the expected outputs, computed from a time-based model
// (last busy cycle per register plus an outstanding-var flag), into a queue.
// A separate monitor pops and compares every cycle.
module tb_reg_scoreboard;

  typedef struct packed {
    logic       ins_v;
    logic [4:0] rd;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       rd_used;
    logic       ra_used;
    logic       rb_used;
    logic       issue_ok;
    logic [6:0] delay;
    logic       issue_var;
    logic       wb_v;
    logic [4:0] wb_addr;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic        rd_c;
    logic        rs_c;
    logic [31:0] pend;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  exp_t exp_q[$];

  int   last_c [32];
  bit   isv    [32];
  bit   err_next;
  int   now;

  reg_scoreboard_if #(.NUM_REGS(32), .REG_ADDR_W(5), .DELAY_W(7)) sb_if ();

  reg_scoreboard #(.NUM_REGS(32), .REG_ADDR_W(5), .DELAY_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit m_pend(int r);
    return (r != 0) && (isv[r] || (now <= last_c[r]));
  endfunction

  function automatic bit m_hz(int r, stim_t s);
    bit h;
    h = m_pend(r);
`ifdef SB_BYPASS_EN
    if (h && !isv[r] && (now == last_c[r])) h = 1'b0;
    if (h && isv[r] && s.wb_v && (int'(s.wb_addr) == r)) h = 1'b0;
`else
    if (s.wb_v && 1'b0) h = 1'b0;
`endif
    return h;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.ins_v     = ($urandom_range(0, 3) != 0);
    s.rd        = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    s.ra        = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    s.rb        = 5'($urandom_range(0, 7));
    s.rd_used   = ($urandom_range(0, 3) != 0);
    s.ra_used   = ($urandom_range(0, 1) != 0);
    s.rb_used   = ($urandom_range(0, 1) != 0);
    s.issue_ok  = ($urandom_range(0, 1) != 0);
    s.delay     = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 5));
    s.issue_var = ($urandom_range(0, 5) == 0);
    s.wb_v      = ($urandom_range(0, 3) == 0);
    s.wb_addr   = 5'($urandom_range(0, 7));
    s.rst       = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  // Drive one cycle, queue the expected outputs, then advance the model
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    int   d;
    int   w;
    @(negedge clk);
    now++;
    reset             = s.rst;
    sb_if.ins_v       = s.ins_v;
    sb_if.rD_addr     = s.rd;
    sb_if.rA_addr     = s.ra;
    sb_if.rB_addr     = s.rb;
    sb_if.rD_used     = s.rd_used;
    sb_if.rA_used     = s.ra_used;
    sb_if.rB_used     = s.rb_used;
    sb_if.issue_ok    = s.issue_ok;
    sb_if.issue_delay = s.delay;
    sb_if.issue_var   = s.issue_var;
    sb_if.wb_v        = s.wb_v;
    sb_if.wb_addr     = s.wb_addr;

    for (int r = 0; r < 32; r++) e.pend[r] = m_pend(r);
    e.rd_c = s.ins_v && s.rd_used && m_pend(int'(s.rd));
    e.rs_c = s.ins_v && ((s.ra_used && m_hz(int'(s.ra), s)) ||
                         (s.rb_used && m_hz(int'(s.rb), s)));
    e.err  = err_next;
    exp_q.push_back(e);

    if (s.rst) begin
      for (int r = 0; r < 32; r++) begin
        isv[r]    = 1'b0;
        last_c[r] = -1;
      end
      err_next = 1'b0;
    end else begin
      w = int'(s.wb_addr);
      d = int'(s.delay);
      err_next = s.wb_v && (w != 0) && !isv[w];
      if (s.wb_v && isv[w]) isv[w] = 1'b0;
      if (s.issue_ok && s.rd_used && (s.rd != 5'd0) && (s.issue_var || d != 0)) begin
        if (s.issue_var) begin
          isv[int'(s.rd)]    = 1'b1;
          last_c[int'(s.rd)] = -1;
        end else begin
          isv[int'(s.rd)]    = 1'b0;
          last_c[int'(s.rd)] = now + d;
        end
      end
    end
  endtask

  task automatic doIssue(input int rd, input int d, input bit v);
    stim_t s;
    s = idle();
    s.ins_v     = 1'b1;
    s.rd        = 5'(rd);
    s.rd_used   = 1'b1;
    s.issue_ok  = 1'b1;
    s.delay     = 7'(d);
    s.issue_var = v;
    applyStimulus(s);
  endtask

  task automatic doRead(input int r);
    stim_t s;
    s = idle();
    s.ins_v   = 1'b1;
    s.ra      = 5'(r);
    s.rb      = 5'(r);
    s.rd      = 5'(r);
    s.ra_used = 1'b1;
    s.rd_used = 1'b1;
    applyStimulus(s);
  endtask

  task automatic doWb(input int r);
    stim_t s;
    s = idle();
    s.wb_v    = 1'b1;
    s.wb_addr = 5'(r);
    applyStimulus(s);
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (sb_if.rD_conflict !== e.rd_c) begin
      bad++;
      $display("[TB] FAIL rD_conflict t=%0t got=%b want=%b", $time, sb_if.rD_conflict, e.rd_c);
    end
    total++;
    if (sb_if.rS_conflict !== e.rs_c) begin
      bad++;
      $display("[TB] FAIL rS_conflict t=%0t got=%b want=%b", $time, sb_if.rS_conflict, e.rs_c);
    end
    total++;
    if (sb_if.pending !== e.pend) begin
      bad++;
      $display("[TB] FAIL pending t=%0t got=%h want=%h", $time, sb_if.pending, e.pend);
    end
    total++;
    if (sb_if.wb_err !== e.err) begin
      bad++;
      $display("[TB] FAIL wb_err t=%0t got=%b want=%b", $time, sb_if.wb_err, e.err);
    end
  endtask

  // Monitor: compare after the stimulus for this cycle has settled
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    stim_t s;
    total    = 0;
    bad      = 0;
    now      = 0;
    err_next = 1'b0;
    for (int r = 0; r < 32; r++) begin
      isv[r]    = 1'b0;
      last_c[r] = -1;
    end
    reset = 1'b1;
    sb_if.ins_v = 1'b0;       sb_if.rD_addr = '0;     sb_if.rA_addr = '0;
    sb_if.rB_addr = '0;       sb_if.rD_used = 1'b0;   sb_if.rA_used = 1'b0;
    sb_if.rB_used = 1'b0;     sb_if.issue_ok = 1'b0;  sb_if.issue_delay = '0;
    sb_if.issue_var = 1'b0;   sb_if.wb_v = 1'b0;      sb_if.wb_addr = '0;
    repeat (2) @(posedge clk);

    // Reset held with arbitrary inputs: everything reads zero
    for (int i = 0; i < 2; i++) begin
      s = rand_stim();
      s.rst = 1'b1;
      applyStimulus(s);
    end

    // Fixed delay 3 on reg 5 with a reader every cycle
    doIssue(5, 3, 1'b0);
    repeat (5) doRead(5);

    // Variable-latency op on reg 7 held for 80 idle cycles, then written back
    doIssue(7, 0, 1'b1);
    repeat (80) applyStimulus(idle());
    doRead(7);
    doWb(7);
    doRead(7);
    applyStimulus(idle());

    // Stray writeback to an idle register
    doWb(9);
    applyStimulus(idle());
    applyStimulus(idle());

    // Same-cycle var clear and fixed reissue on reg 7
    doIssue(7, 0, 1'b1);
    applyStimulus(idle());
    s = idle();
    s.wb_v = 1'b1;   s.wb_addr = 5'd7;
    s.ins_v = 1'b1;  s.rd = 5'd7;  s.rd_used = 1'b1;  s.issue_ok = 1'b1;  s.delay = 7'd2;
    applyStimulus(s);
    repeat (3) doRead(7);

    // Reg 0 is never marked and never conflicts
    doIssue(0, 4, 1'b0);
    doRead(0);
    doWb(0);
    applyStimulus(idle());

    // Reset in the middle of a long countdown
    doIssue(3, 10, 1'b0);
    repeat (3) doRead(3);
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    doRead(3);

    // Var entry dropped by reset; the late writeback is then an error
    doIssue(8, 0, 1'b1);
    doRead(8);
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    doWb(8);
    applyStimulus(idle());

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(rand_stim());
    end
    applyStimulus(idle());

    @(negedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
